// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, one-hot status codes, register IDs,
// and the M pipeline register layout with its bubble value.
package y86_pkg;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  localparam logic [3:0] STAT_AOK = 4'b1000;
  localparam logic [3:0] STAT_HLT = 4'b0100;
  localparam logic [3:0] STAT_ADR = 4'b0010;
  localparam logic [3:0] STAT_INS = 4'b0001;

  localparam logic [3:0] RNONE = 4'hF;

  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } m_reg_t;

  // A bubble is a nop that writes no register and can never fault.
  localparam m_reg_t M_BUBBLE = '{
    stat:  STAT_AOK,
    icode: ICODE_NOP,
    cnd:   1'b0,
    val_e: 64'd0,
    val_a: 64'd0,
    dst_e: RNONE,
    dst_m: RNONE
  };

endpackage

// File: rtl/m_stage_regs.sv
// M pipeline register: loads the execute-stage results each edge, or a bubble
// on reset or M_bubble.
module m_stage_regs
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        M_bubble,
  input  logic [3:0]  e_stat,
  input  logic [3:0]  e_icode,
  input  logic        e_Cnd,
  input  logic [63:0] e_valE,
  input  logic [63:0] e_valA,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  e_dstM,
  output logic [3:0]  M_stat,
  output logic [3:0]  M_icode,
  output logic        M_Cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM
);

  m_reg_t regs_q;
  m_reg_t regs_d;

  always_comb begin
    regs_d = '{
      stat:  e_stat,
      icode: e_icode,
      cnd:   e_Cnd,
      val_e: e_valE,
      val_a: e_valA,
      dst_e: e_dstE,
      dst_m: e_dstM
    };
    if (M_bubble) begin
      regs_d = M_BUBBLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= M_BUBBLE;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign M_stat  = regs_q.stat;
  assign M_icode = regs_q.icode;
  assign M_Cnd   = regs_q.cnd;
  assign M_valE  = regs_q.val_e;
  assign M_valA  = regs_q.val_a;
  assign M_dstE  = regs_q.dst_e;
  assign M_dstM  = regs_q.dst_m;

endmodule

// File: rtl/memory_stage.sv
// Y86-64 memory stage: M register, address/control decode and a word-organised
// data memory with combinational read and write-on-edge.
module memory_stage
  import y86_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        M_bubble,
  input  logic [3:0]  e_stat,
  input  logic [3:0]  e_icode,
  input  logic        e_Cnd,
  input  logic [63:0] e_valE,
  input  logic [63:0] e_valA,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  e_dstM,
  output logic [3:0]  M_stat,
  output logic [3:0]  M_icode,
  output logic        M_Cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
  output logic [3:0]  m_stat,
  output logic [3:0]  m_icode,
  output logic [63:0] m_valE,
  output logic [63:0] m_valM,
  output logic [3:0]  m_dstE,
  output logic [3:0]  m_dstM
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [63:0] mem_q [MEM_WORDS];

  logic          mem_read;
  logic          mem_write;
  logic [63:0]   mem_addr;
  logic          mem_error;
  logic [AW-1:0] mem_idx;
  logic          write_en;

  m_stage_regs u_regs (
    .clk      (clk),
    .reset    (reset),
    .M_bubble (M_bubble),
    .e_stat   (e_stat),
    .e_icode  (e_icode),
    .e_Cnd    (e_Cnd),
    .e_valE   (e_valE),
    .e_valA   (e_valA),
    .e_dstE   (e_dstE),
    .e_dstM   (e_dstM),
    .M_stat   (M_stat),
    .M_icode  (M_icode),
    .M_Cnd    (M_Cnd),
    .M_valE   (M_valE),
    .M_valA   (M_valA),
    .M_dstE   (M_dstE),
    .M_dstM   (M_dstM)
  );

  // popq/ret address the stack through valA; everything else uses valE.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = M_valE;
    case (M_icode)
      ICODE_MRMOVQ: mem_read = 1'b1;
      ICODE_POPQ,
      ICODE_RET: begin
        mem_read = 1'b1;
        mem_addr = M_valA;
      end
      ICODE_RMMOVQ,
      ICODE_PUSHQ,
      ICODE_CALL: mem_write = 1'b1;
      default: ;
    endcase
  end

  assign mem_error = (mem_read || mem_write) && (mem_addr >= 64'(MEM_WORDS));
  assign mem_idx   = mem_addr[AW-1:0];
  assign write_en  = mem_write && !mem_error && (M_stat == STAT_AOK);

  // Reset clearing wins over a store sitting in M.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem_q[i] <= 64'd0;
      end
    end else if (write_en) begin
      mem_q[mem_idx] <= M_valA;
    end
  end

  assign m_valM  = (mem_read && !mem_error) ? mem_q[mem_idx] : 64'd0;
  assign m_stat  = mem_error ? STAT_ADR : M_stat;
  assign m_icode = M_icode;
  assign m_valE  = M_valE;
  assign m_dstE  = M_dstE;
  assign m_dstM  = M_dstM;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboarded bench for memory_stage: the driver predicts each instruction's
// M/m outputs from a sparse memory model, the monitor checks them a cycle later.
module tb_memory_stage;
  import y86_pkg::*;

  localparam int W = 289;
  localparam logic [63:0] WORDS = 64'd1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        M_bubble = 1'b0;
  logic [3:0]  e_stat = STAT_AOK;
  logic [3:0]  e_icode = ICODE_NOP;
  logic        e_Cnd = 1'b0;
  logic [63:0] e_valE = '0;
  logic [63:0] e_valA = '0;
  logic [3:0]  e_dstE = RNONE;
  logic [3:0]  e_dstM = RNONE;
  logic [3:0]  M_stat, M_icode, M_dstE, M_dstM;
  logic        M_Cnd;
  logic [63:0] M_valE, M_valA;
  logic [3:0]  m_stat, m_icode, m_dstE, m_dstM;
  logic [63:0] m_valE, m_valM;

  logic [W-1:0] exp_q[$];
  logic [63:0]  mem_m [logic [63:0]];
  int tests = 0;
  int fails = 0;

  memory_stage #(.MEM_WORDS(1024)) dut (
    .clk(clk), .reset(reset), .M_bubble(M_bubble),
    .e_stat(e_stat), .e_icode(e_icode), .e_Cnd(e_Cnd),
    .e_valE(e_valE), .e_valA(e_valA), .e_dstE(e_dstE), .e_dstM(e_dstM),
    .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valE(M_valE),
    .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .m_stat(m_stat), .m_icode(m_icode), .m_valE(m_valE), .m_valM(m_valM),
    .m_dstE(m_dstE), .m_dstM(m_dstM)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Drive one instruction for the next edge and predict what the stage shows
  // while it sits in M. Earlier stores are already in mem_m at that point.
  task automatic drive(input logic rst, input logic bub, input logic [3:0] st,
                       input logic [3:0] ic, input logic cnd, input logic [63:0] ve,
                       input logic [63:0] va, input logic [3:0] de, input logic [3:0] dm);
    logic [3:0]  xs, xi, xde, xdm, xms;
    logic        xc;
    logic [63:0] xve, xva, xvm, addr;
    bit          rd, wr, err;
    @(negedge clk);
    reset = rst; M_bubble = bub; e_stat = st; e_icode = ic; e_Cnd = cnd;
    e_valE = ve; e_valA = va; e_dstE = de; e_dstM = dm;
    if (rst) mem_m.delete();
    if (rst || bub) begin
      xs = STAT_AOK; xi = ICODE_NOP; xc = 1'b0; xve = '0; xva = '0;
      xde = RNONE; xdm = RNONE; xvm = '0; xms = STAT_AOK;
    end else begin
      xs = st; xi = ic; xc = cnd; xve = ve; xva = va; xde = de; xdm = dm;
      rd = (ic == ICODE_MRMOVQ) || (ic == ICODE_POPQ) || (ic == ICODE_RET);
      wr = (ic == ICODE_RMMOVQ) || (ic == ICODE_PUSHQ) || (ic == ICODE_CALL);
      addr = (ic == ICODE_POPQ || ic == ICODE_RET) ? va : ve;
      err = (rd || wr) && (addr >= WORDS);
      xms = err ? STAT_ADR : st;
      xvm = (rd && !err && mem_m.exists(addr)) ? mem_m[addr] : 64'd0;
      if (wr && !err && st == STAT_AOK) mem_m[addr] = va;
    end
    exp_q.push_back({xs, xi, xc, xve, xva, xde, xdm, xms, xi, xve, xvm, xde, xdm});
  endtask

  function automatic logic [63:0] rand_addr();
    case ($urandom_range(0, 9))
      0: return 64'd1023;
      1: return 64'd1024;
      2: return {$urandom(), $urandom()};
      default: return 64'($urandom_range(0, 15));
    endcase
  endfunction

  function automatic logic [3:0] rand_stat();
    case ($urandom_range(0, 7))
      0: return STAT_HLT;
      1: return STAT_INS;
      default: return STAT_AOK;
    endcase
  endfunction

  // scoreboard monitor
  initial begin
    logic [W-1:0] exp_v, act_v;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM,
                 m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM};
        tests++;
        if (act_v !== exp_v) begin
          fails++;
          $display("FAIL stage_out t=%0t got=%h exp=%h", $time, act_v, exp_v);
        end
      end
    end
  end

  // stimulus
  initial begin
    drive(1, 0, STAT_AOK, ICODE_NOP, 0, 0, 0, RNONE, RNONE);
    drive(0, 0, STAT_AOK, ICODE_HALT, 0, 64'd10, 64'd20, 4'd10, 4'd9);
    drive(0, 0, STAT_AOK, ICODE_NOP, 0, 64'd2000, 64'd49, RNONE, RNONE);
    drive(0, 0, STAT_AOK, ICODE_MRMOVQ, 0, 64'd100, 64'd0, RNONE, 4'd3);
    drive(0, 0, STAT_AOK, ICODE_RMMOVQ, 1, 64'd200, 64'd109, RNONE, RNONE);
    drive(0, 0, STAT_AOK, ICODE_MRMOVQ, 0, 64'd200, 64'd0, RNONE, 4'd2);
    drive(0, 0, STAT_AOK, ICODE_MRMOVQ, 0, 64'd5000, 64'd0, RNONE, 4'd2);
    drive(0, 0, STAT_AOK, ICODE_RMMOVQ, 0, 64'd5000, 64'd77, RNONE, RNONE);
    drive(0, 0, STAT_AOK, ICODE_MRMOVQ, 0, 64'd904, 64'd0, RNONE, 4'd1);
    drive(0, 1, STAT_AOK, ICODE_MRMOVQ, 1, 64'd200, 64'd5, 4'd4, 4'd5);
    drive(0, 0, STAT_AOK, ICODE_POPQ, 0, 64'd8, 64'd200, 4'd4, 4'd6);
    drive(0, 0, STAT_HLT, ICODE_RMMOVQ, 0, 64'd7, 64'd55, RNONE, RNONE);
    drive(0, 0, STAT_AOK, ICODE_RET, 0, 64'd8, 64'd7, 4'd4, RNONE);
    drive(0, 0, STAT_AOK, ICODE_PUSHQ, 0, 64'd1023, 64'hDEAD_BEEF, 4'd4, RNONE);
    drive(0, 0, STAT_AOK, ICODE_CALL, 0, 64'd1024, 64'h33, 4'd4, RNONE);
    drive(0, 0, STAT_AOK, ICODE_POPQ, 0, 64'd0, 64'd1023, 4'd4, 4'd0);
    // store followed by reset: write must be discarded
    drive(0, 0, STAT_AOK, ICODE_RMMOVQ, 0, 64'd3, 64'h1234, RNONE, RNONE);
    drive(1, 1, STAT_AOK, ICODE_MRMOVQ, 0, 64'd3, 64'd0, RNONE, RNONE);
    drive(0, 0, STAT_AOK, ICODE_MRMOVQ, 0, 64'd3, 64'd0, RNONE, 4'd1);
    drive(0, 0, STAT_AOK, ICODE_MRMOVQ, 0, 64'd200, 64'd0, RNONE, 4'd1);
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0, rand_stat(),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            rand_addr(), ($urandom_range(0, 1) == 1) ? {$urandom(), $urandom()} : rand_addr(),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    repeat (3) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
